// File: rtl/sw_debounce_pkg.sv
// Shared constants for the switch debouncer: channel counts and the default debounce length.
// Latency: n/a (constants only).
// Backpressure: n/a.
package sw_debounce_pkg;

   localparam int N_SW          = 8;       // data switches
   localparam int N_CH          = 9;       // data switches plus the enable switch
   localparam int EN_CH         = 8;       // channel index carrying en_raw
   localparam int DB_CYCLES_DEF = 250000;  // 5 ms at 50 MHz

endpackage

// File: rtl/sw_debounce_bit.sv
// One debounce channel: 2-flop synchronizer, stability counter, stable flop and update strobe.
// Latency: a clean raw step reaches stable 2 + DB_CYCLES edges after the first sampling edge.
// Backpressure: none; free-running per clk.
module sw_debounce_bit #(
   parameter int DB_CYCLES = 250000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic stable,
   output logic upd,
   output logic busy
);

   localparam int              CNT_W    = $clog2(DB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic             s1;
   logic             s2;
   logic [CNT_W-1:0] cnt;

   // Synchronizer: s1 is only ever copied into s2 so it has a full cycle to resolve.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

   // Strobe for the cycle in which stable takes the synchronized value.
   assign upd  = (s2 != stable) && (cnt == CNT_LAST);
   assign busy = (cnt != '0);

   // Count consecutive disagreeing samples; any agreeing sample restarts from zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt    <= '0;
         stable <= 1'b0;
      end else if (s2 == stable) begin
         cnt    <= '0;
      end else if (cnt == CNT_LAST) begin
         stable <= s2;
         cnt    <= '0;
      end else begin
         cnt    <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/sw_debounce.sv
// Debounces 8 board switches plus the enable switch for the priority encoder; flags updates and quiescence.
// Latency: 2 + DB_CYCLES clk edges from first sampling edge to sw/en; changed coincides with the update.
// Backpressure: none. Optional sw_rise/sw_fall outputs exist when SW_DEBOUNCE_EDGE_EN is defined.
module sw_debounce
   import sw_debounce_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_SW-1:0]   sw_raw,
   input  logic              en_raw,
   output logic [N_SW-1:0]   sw,
   output logic              en,
   output logic              changed,
   output logic              settled
`ifdef SW_DEBOUNCE_EDGE_EN
   ,
   output logic [N_CH-1:0]   sw_rise,
   output logic [N_CH-1:0]   sw_fall
`endif
);

   logic [N_CH-1:0] raw_vec;
   logic [N_CH-1:0] stable_vec;
   logic [N_CH-1:0] upd_vec;
   logic [N_CH-1:0] busy_vec;

   assign raw_vec = {en_raw, sw_raw};

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      sw_debounce_bit #(
         .DB_CYCLES (DB_CYCLES)
      ) u_bit (
         .clk    (clk),
         .rst    (rst),
         .raw    (raw_vec[g]),
         .stable (stable_vec[g]),
         .upd    (upd_vec[g]),
         .busy   (busy_vec[g])
      );
   end

   assign sw      = stable_vec[N_SW-1:0];
   assign en      = stable_vec[EN_CH];
   assign settled = ~|busy_vec;

   // Single pulse for any number of channels updating together, aligned with the new stable value.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         changed <= 1'b0;
      end else begin
         changed <= |upd_vec;
      end
   end

`ifdef SW_DEBOUNCE_EDGE_EN
   // Direction of each update is decided by the stable value it is replacing.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sw_rise <= '0;
         sw_fall <= '0;
      end else begin
         sw_rise <= upd_vec & ~stable_vec;
         sw_fall <= upd_vec &  stable_vec;
      end
   end
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce at DB_CYCLES=4: table vectors through a scoreboard plus exact-latency sequences.
// Latency: checks 2 + DB_CYCLES edges from the first sampling edge.
// Backpressure: n/a.
module tb_sw_debounce;

   localparam int DB  = 4;
   localparam int LAT = 2 + DB;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] sw_raw;
   logic       en_raw;
   logic [7:0] sw;
   logic       en;
   logic       changed;
   logic       settled;
`ifdef SW_DEBOUNCE_EDGE_EN
   logic [8:0] sw_rise;
   logic [8:0] sw_fall;
`endif

   always #5 clk = ~clk;

   sw_debounce #(.DB_CYCLES(DB)) dut (
      .clk     (clk),
      .rst     (rst),
      .sw_raw  (sw_raw),
      .en_raw  (en_raw),
      .sw      (sw),
      .en      (en),
      .changed (changed),
      .settled (settled)
`ifdef SW_DEBOUNCE_EDGE_EN
      ,
      .sw_rise (sw_rise),
      .sw_fall (sw_fall)
`endif
   );

   typedef struct {
      logic [7:0] sw_raw;
      logic       en_raw;
      logic [7:0] exp_sw;
      logic       exp_en;
      int         exp_chg;
   } vec_t;

   typedef struct {
      logic [7:0] exp_sw;
      logic       exp_en;
      int         exp_chg;
   } exp_t;

   vec_t vec[6];
   exp_t sb[$];

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", nm, act, req);
      end
   endtask

   // Advance one active edge and land on the following falling edge, where we sample and drive.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Inputs are already driven; check the exact update edge, changed pulse and settled window.
   task automatic watch(input string nm, input logic [7:0] new_s, input logic new_e,
                        input logic [7:0] old_s, input logic old_e);
      logic [8:0] nv;
      logic [8:0] ov;
      nv = {new_e, new_s};
      ov = {old_e, old_s};
      for (int k = 1; k <= LAT; k++) begin
         tick();
         chk({nm, "_sw"},  32'(sw),      32'((k == LAT) ? new_s : old_s));
         chk({nm, "_en"},  32'(en),      32'((k == LAT) ? new_e : old_e));
         chk({nm, "_chg"}, 32'(changed), 32'(k == LAT));
         chk({nm, "_set"}, 32'(settled), 32'(!(k >= 3 && k < LAT)));
`ifdef SW_DEBOUNCE_EDGE_EN
         chk({nm, "_rise"}, 32'(sw_rise), 32'((k == LAT) ? (nv & ~ov) : 9'h0));
         chk({nm, "_fall"}, 32'(sw_fall), 32'((k == LAT) ? (ov & ~nv) : 9'h0));
`else
         if (nv == ov) $display("note: %s drives no change", nm);
`endif
      end
      tick();
      chk({nm, "_chg_end"}, 32'(changed), 32'(0));
      chk({nm, "_set_end"}, 32'(settled), 32'(1));
   endtask

   initial begin
      exp_t e;
      int   pulses;

      vec[0] = '{8'hA5, 1'b1, 8'hA5, 1'b1, 1};
      vec[1] = '{8'hA5, 1'b1, 8'hA5, 1'b1, 0};
      vec[2] = '{8'h5A, 1'b0, 8'h5A, 1'b0, 1};
      vec[3] = '{8'hFF, 1'b0, 8'hFF, 1'b0, 1};
      vec[4] = '{8'h80, 1'b1, 8'h80, 1'b1, 1};
      vec[5] = '{8'h00, 1'b0, 8'h00, 1'b0, 1};

      // Reset held with all switches high: nothing may leak through.
      rst    = 1'b0;
      sw_raw = 8'hFF;
      en_raw = 1'b1;
      repeat (3) tick();
      chk("rst_sw",  32'(sw),      32'(0));
      chk("rst_en",  32'(en),      32'(0));
      chk("rst_chg", 32'(changed), 32'(0));
      chk("rst_set", 32'(settled), 32'(1));
      rst = 1'b1;
      watch("release", 8'hFF, 1'b1, 8'h00, 1'b0);

      // Clean steps.
      sw_raw = 8'h00; en_raw = 1'b0;
      watch("fall_all", 8'h00, 1'b0, 8'hFF, 1'b1);
      sw_raw = 8'h04;
      watch("step04", 8'h04, 1'b0, 8'h00, 1'b0);

      // Three-cycle glitch on bit 7 must be absorbed.
      sw_raw = 8'h84;
      repeat (3) tick();
      sw_raw = 8'h04;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (changed !== 1'b0 || sw !== 8'h04) chk("glitch_out", {23'd0, changed, sw}, 32'h04);
      end
      chk("glitch_sw",  32'(sw),      32'h04);
      chk("glitch_set", 32'(settled), 32'(1));

      // Table vectors through the scoreboard.
      for (int i = 0; i < 6; i++) begin
         sw_raw = vec[i].sw_raw;
         en_raw = vec[i].en_raw;
         sb.push_back('{vec[i].exp_sw, vec[i].exp_en, vec[i].exp_chg});
         pulses = 0;
         for (int k = 0; k < LAT + 2; k++) begin
            tick();
            if (changed) pulses++;
         end
         e = sb.pop_front();
         chk($sformatf("vec%0d_sw", i),  32'(sw),      32'(e.exp_sw));
         chk($sformatf("vec%0d_en", i),  32'(en),      32'(e.exp_en));
         chk($sformatf("vec%0d_chg", i), 32'(pulses),  32'(e.exp_chg));
         chk($sformatf("vec%0d_set", i), 32'(settled), 32'(1));
      end

      // Bounce on bit 1: the 0 sample restarts the count.
      sw_raw = 8'h02; tick();
      sw_raw = 8'h00; tick();
      sw_raw = 8'h02;
      for (int k = 1; k <= LAT; k++) begin
         tick();
         chk($sformatf("bounce_k%0d", k), 32'(sw), 32'((k == LAT) ? 8'h02 : 8'h00));
      end
      sw_raw = 8'h00;
      repeat (LAT + 2) tick();
      chk("bounce_back", 32'(sw), 32'(0));

      // Simultaneous update of sw[0] and en.
      sw_raw = 8'h01; en_raw = 1'b1;
      watch("simul", 8'h01, 1'b1, 8'h00, 1'b0);

      // Reset in the middle of a count.
      sw_raw = 8'h10; en_raw = 1'b1;
      repeat (4) tick();
      chk("mid_busy", 32'(settled), 32'(0));
      rst = 1'b0;
      #1;
      chk("mid_sw",  32'(sw),      32'(0));
      chk("mid_en",  32'(en),      32'(0));
      chk("mid_chg", 32'(changed), 32'(0));
      chk("mid_set", 32'(settled), 32'(1));
      @(negedge clk);
      tick();
      chk("mid_hold_sw", 32'(sw), 32'(0));
      rst = 1'b1;
      watch("requal", 8'h10, 1'b1, 8'h00, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
